// File: rtl/lcd_stream.sv
// HD44780 4-bit write-only driver: power-up wait, init/config, then 2x16 character refresh on cls.
// Optional LCD_PENDING_REFRESH_EN: a cls seen while busy queues one refresh for when IDLE is reached.
module lcd_stream #(
  parameter int POWERUP_CYC = 750000,
  parameter int E_CYC       = 12,
  parameter int NIB_GAP     = 50,
  parameter int CMD_WAIT    = 2000,
  parameter int CLR_WAIT    = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [3:0]   lcd_d,
  output logic         busy
);

  typedef enum logic [2:0] {PWRUP, INIT, CFG, IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_E, PH_GAP, PH_WAIT} phase_t;

  localparam int MAX_A = (POWERUP_CYC > CLR_WAIT) ? POWERUP_CYC : CLR_WAIT;
  localparam int MAX_B = (CMD_WAIT > NIB_GAP) ? CMD_WAIT : NIB_GAP;
  localparam int MAX_C = (MAX_B > E_CYC) ? MAX_B : E_CYC;
  localparam int MAX_W = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW    = $clog2(MAX_W + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(NIB_GAP - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

  // Byte (or, in INIT, the nibble in bits [7:4]) carried by a given state/index.
  function automatic logic [7:0] byte_of(input state_t s, input logic [4:0] idx,
                                         input logic [255:0] b);
    byte_of = 8'h00;
    case (s)
      INIT:          byte_of = (idx[1:0] == 2'd3) ? 8'h20 : 8'h30;
      CFG: begin
        case (idx[1:0])
          2'd0:    byte_of = 8'h28;
          2'd1:    byte_of = 8'h0C;
          2'd2:    byte_of = 8'h06;
          default: byte_of = 8'h01;
        endcase
      end
      ADDR1:         byte_of = 8'h80;
      ADDR2:         byte_of = 8'hC0;
      LINE1, LINE2:  byte_of = b[(8'd255 - {idx, 3'b000}) -: 8];
      default:       byte_of = 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     idx_q, idx_d;
  logic           hi_q, hi_d;
  logic [255:0]   buf_q, buf_d;
  logic           e_q, e_d;
  logic           rs_q, rs_d;
  logic [3:0]     d_q, d_d;
  logic [7:0]     byte_d;
  logic [CW-1:0]  wait_last;
  logic           go;
`ifdef LCD_PENDING_REFRESH_EN
  logic           pend_q, pend_d;
  assign go = cls | pend_q;
`else
  assign go = cls;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    buf_d   = buf_q;
`ifdef LCD_PENDING_REFRESH_EN
    pend_d  = (state_q == IDLE) ? 1'b0 : (pend_q | cls);
`endif
    wait_last = (state_q == INIT || (state_q == CFG && idx_q[1:0] == 2'd3)) ? CLR_LAST : CMD_LAST;

    case (state_q)
      PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          hi_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (go) begin
          buf_d   = strdata;
          state_d = ADDR1;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          hi_d    = 1'b1;
        end
      end
      default: begin
        unique case (phase_q)
          PH_SETUP: begin
            phase_d = PH_E;
            cnt_d   = '0;
          end
          PH_E: begin
            if (cnt_q == E_LAST) begin
              phase_d = PH_GAP;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
          end
          PH_GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_d = '0;
              // INIT nibbles are single; everything else sends the low nibble next.
              if (hi_q && state_q != INIT) begin
                hi_d    = 1'b0;
                phase_d = PH_SETUP;
              end else phase_d = PH_WAIT;
            end else cnt_d = cnt_q + 1'b1;
          end
          PH_WAIT: begin
            if (cnt_q == wait_last) begin
              cnt_d   = '0;
              hi_d    = 1'b1;
              phase_d = PH_SETUP;
              case (state_q)
                INIT:  begin
                  if (idx_q[1:0] == 2'd3) begin state_d = CFG; idx_d = '0; end
                  else idx_d = idx_q + 1'b1;
                end
                CFG:   begin
                  if (idx_q[1:0] == 2'd3) begin state_d = IDLE; idx_d = '0; end
                  else idx_d = idx_q + 1'b1;
                end
                ADDR1: begin state_d = LINE1; idx_d = '0; end
                LINE1: begin
                  if (idx_q == 5'd15) state_d = ADDR2;
                  idx_d = idx_q + 1'b1;
                end
                ADDR2: state_d = LINE2;
                LINE2: begin
                  if (idx_q == 5'd31) begin state_d = IDLE; idx_d = '0; end
                  else idx_d = idx_q + 1'b1;
                end
                default: ;
              endcase
            end else cnt_d = cnt_q + 1'b1;
          end
        endcase
      end
    endcase

    // Bus outputs are registered from the next state so they never glitch.
    byte_d = byte_of(state_d, idx_d, buf_d);
    e_d    = (state_d != PWRUP) && (state_d != IDLE) && (phase_d == PH_E);
    rs_d   = (state_d == LINE1) || (state_d == LINE2);
    d_d    = hi_d ? byte_d[7:4] : byte_d[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      hi_q    <= 1'b1;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= 4'h0;
`ifdef LCD_PENDING_REFRESH_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
`ifdef LCD_PENDING_REFRESH_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // NOTE: the character buffer is pure storage, always written before it is read, so it has no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_d  = d_q;
  assign lcd_rw = 1'b0;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/lcd_stream.md
LCD_STREAM -- requirements
Module: lcd_stream

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 750000, meaning cycles of power-up wait before the first LCD access.
REQ-002 SHALL have parameter E_CYC, default 12, meaning cycles lcd_e is held high per nibble.
REQ-003 SHALL have parameter NIB_GAP, default 50, meaning cycles lcd_e is low after each nibble.
REQ-004 SHALL have parameter CMD_WAIT, default 2000, meaning cycles of wait after each byte other than clear.
REQ-005 SHALL have parameter CLR_WAIT, default 82000, meaning cycles of wait after clear (0x01) and after each init nibble.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port cls, input, 1, refresh request, sampled every clk.
REQ-009 SHALL have port strdata, input, 256, 32 ASCII chars; [255:248] is line-1 col 0, [127:120] is line-2 col 0, [7:0] is line-2 col 15.
REQ-010 SHALL have ports lcd_rs, lcd_rw, lcd_e (outputs, 1 each) and lcd_d (output, 4), the HD44780 4-bit bus.
REQ-011 SHALL have port busy, output, 1, high whenever not in IDLE.

Function
REQ-012 SHALL tie lcd_rw to 0 at all times (write-only).
REQ-013 SHALL send each nibble as: lcd_d/lcd_rs valid 1 cycle with lcd_e=0, then lcd_e=1 for E_CYC cycles, then lcd_e=0 for NIB_GAP cycles, with lcd_d/lcd_rs stable throughout.
REQ-014 SHALL send each byte as the high nibble then the low nibble, then wait CMD_WAIT cycles (CLR_WAIT for 0x01).
REQ-015 SHALL use states PWRUP -> INIT -> CFG -> IDLE -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> IDLE.
REQ-016 PWRUP SHALL wait POWERUP_CYC cycles; INIT SHALL send the single nibbles 0x3, 0x3, 0x3, 0x2 (rs=0), each followed by a CLR_WAIT wait.
REQ-017 CFG SHALL send the bytes 0x28, 0x0C, 0x06, 0x01 (rs=0) in order, then enter IDLE.
REQ-018 In IDLE with cls=1, SHALL latch strdata into an internal 256-bit buffer the same cycle and move to ADDR1 next cycle.
REQ-019 ADDR1 SHALL send 0x80 (rs=0); LINE1 SHALL send buffer chars 0..15 (rs=1); ADDR2 SHALL send 0xC0 (rs=0); LINE2 SHALL send chars 16..31 (rs=1).
REQ-020 SHALL use a 5-bit character index that runs 0..31 and ends the refresh at 31 with no wrap.
REQ-021 Changes on strdata during a refresh SHALL NOT affect the characters sent.
REQ-022 cls asserted before IDLE is reached (PWRUP/INIT/CFG) SHALL be handled per REQ-027/028, never by aborting init.
REQ-023 The wait counter SHALL be wide enough for max(POWERUP_CYC, CLR_WAIT) and SHALL NOT wrap.

Reset
REQ-024 On rst=1 at a clk edge: state=PWRUP, counters=0, pending=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, busy=1.
REQ-025 rst mid-transfer SHALL abort immediately; the next access SHALL be the full PWRUP/INIT/CFG sequence.
REQ-026 The buffer SHALL NOT require reset.

Configuration
REQ-027 With LCD_PENDING_REFRESH_EN defined: cls=1 while busy SHALL set a pending flag; on entering IDLE with pending=1, SHALL latch strdata, clear pending, and start a refresh (one pending max).
REQ-028 Without LCD_PENDING_REFRESH_EN: cls=1 while busy SHALL be ignored; no pending flag SHALL exist.

Verification (sim params POWERUP_CYC=20, E_CYC=2, NIB_GAP=3, CMD_WAIT=5, CLR_WAIT=10)
REQ-029 Reset release -> first lcd_e rise after 20 cycles; nibble trace 3,3,3,2 then 2,8,0,C,0,6,0,1 with rs=0; busy falls after the 0x01 wait.
REQ-030 IDLE, strdata="01234567 01 01  0 1 2 01        ", cls 1-cycle pulse -> bytes 0x80, 0x30..0x37, 0x20, 0x30, 0x31, ..., 0xC0, ..., 0x20 decoded on lcd_e falling edges; rs correct per byte; each lcd_e high exactly 2 cycles.
REQ-031 Change strdata mid-refresh -> decoded line matches the value latched at the cls cycle.
REQ-032 cls pulse during LINE1 -> with macro: a second full refresh follows immediately after; without: busy drops and no further lcd_e pulses.
REQ-033 rst asserted during LINE2 -> lcd_e=0 next cycle; busy=1; full init trace repeats before any character is sent.
REQ-034 cls held high continuously -> with macro, back-to-back refreshes with busy low for exactly 1 cycle between them.
